// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM state
// encoding, default geometry and address-field width helpers.
package cache_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_FLUSH  = 2'd3
  } cache_state_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_LINE_W  = 128;
  localparam int DEF_SETS    = 64;
  localparam int DEF_WAYS    = 2;

  function automatic int byte_off_w(input int instr_w);
    return $clog2(instr_w / 8);
  endfunction

  function automatic int word_off_w(input int line_w, input int instr_w);
    return $clog2(line_w / instr_w);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag is whatever is left above index, word offset and byte offset.
  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - $clog2(line_w / 8) - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the instruction cache: tag and line storage plus per-set valid
// bits. Reads are combinational so a lookup completes in a single cycle.
module icache_way_array
  import cache_defs::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int TAG_W  = 22,
  parameter int LINE_W = DEF_LINE_W,
  parameter int IDX_W  = index_w(DEF_SETS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              wr_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i,
  input  logic              clr_en_i,
  input  logic [IDX_W-1:0]  clr_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o
);

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] line_mem [SETS];
  logic [SETS-1:0]   valid_q;

  // Only the valid bits need a reset; stale tags/lines are masked by them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (clr_en_i) valid_q[clr_idx_i] <= 1'b0;
      if (wr_en_i)  valid_q[idx_i]     <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_mem[idx_i]  <= wr_tag_i;
      line_mem[idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_tag_o   = tag_mem[idx_i];
  assign rd_line_o  = line_mem[idx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with single-line refill and sequential
// flush. Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module icache_assoc
  import cache_defs::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int SETS    = DEF_SETS,
  parameter int WAYS    = DEF_WAYS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               imem_sel_i,
  input  logic               if_req_i,
  input  logic               if_req_kill_i,
  input  logic               if_flush_i,
  input  logic [ADDR_W-1:0]  if_addr_i,
  output logic               if_ack_o,
  output logic [INSTR_W-1:0] if_data_o,
  output logic               if_busy_o,
  output logic               mem_req_o,
  output logic               mem_kill_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [LINE_W-1:0]  mem_data_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  localparam int BOFF_W = byte_off_w(INSTR_W);
  localparam int WOFF_W = word_off_w(LINE_W, INSTR_W);
  localparam int OFF_W  = BOFF_W + WOFF_W;
  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  cache_state_e      state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              flush_pend_q;
  logic [IDX_W-1:0]  flush_cnt_q;
  logic [WAY_W-1:0]  rr_q [SETS];

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WOFF_W-1:0] woff_q;
  logic [WAYS-1:0]   way_valid, way_hit, way_wr;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  logic [LINE_W-1:0] hit_line;
  logic [WAY_W-1:0]  victim;
  logic              victim_found, set_full;
  logic              lookup_hit, refill_fire;

  assign tag_q  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_q  = addr_q[OFF_W +: IDX_W];
  assign woff_q = addr_q[BOFF_W +: WOFF_W];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_array #(
      .SETS   (SETS),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W),
      .IDX_W  (IDX_W)
    ) u_way (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .idx_i      (idx_q),
      .wr_en_i    (way_wr[w]),
      .wr_tag_i   (tag_q),
      .wr_line_i  (mem_data_i),
      .clr_en_i   (state_q == ST_FLUSH),
      .clr_idx_i  (flush_cnt_q),
      .rd_valid_o (way_valid[w]),
      .rd_tag_o   (way_tag[w]),
      .rd_line_o  (way_line[w])
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == tag_q);
    assign way_wr[w]  = refill_fire && (victim == WAY_W'(w));
  end

  // Victim is the lowest invalid way; a full set falls back to its RR pointer.
  always_comb begin
    hit_line     = '0;
    victim       = rr_q[idx_q];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_line = way_line[w];
      if (!victim_found && !way_valid[w]) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign set_full    = &way_valid;
  assign lookup_hit  = (state_q == ST_LOOKUP) && (|way_hit) && !if_req_kill_i;
  assign refill_fire = (state_q == ST_REFILL) && mem_ack_i && !if_req_kill_i;

  assign if_ack_o   = lookup_hit || refill_fire;
  assign if_data_o  = lookup_hit  ? hit_line[woff_q*INSTR_W +: INSTR_W] :
                      refill_fire ? mem_data_i[woff_q*INSTR_W +: INSTR_W] : '0;
  assign if_busy_o  = (state_q == ST_FLUSH);
  assign mem_req_o  = (state_q == ST_REFILL) && !if_req_kill_i;
  assign mem_kill_o = (state_q == ST_REFILL) && if_req_kill_i;
  assign mem_addr_o = (state_q == ST_REFILL) ? (addr_q & LINE_MASK) : '0;

  // A flush arriving mid-access is parked until the access has finished.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_flush_i || flush_pend_q) begin
            state_q      <= ST_FLUSH;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
          end else if (if_req_i && imem_sel_i && !if_req_kill_i) begin
            addr_q  <= if_addr_i;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (if_flush_i) flush_pend_q <= 1'b1;
          state_q <= (if_req_kill_i || (|way_hit)) ? ST_IDLE : ST_REFILL;
        end
        ST_REFILL: begin
          if (if_flush_i) flush_pend_q <= 1'b1;
          if (if_req_kill_i || mem_ack_i) state_q <= ST_IDLE;
        end
        ST_FLUSH: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == IDX_W'(SETS - 1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (refill_fire && set_full) begin
      rr_q[idx_q] <= (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_q] + 1'b1;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Misses are counted when the refill lands, so killed refills never count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state_q == ST_FLUSH) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (lookup_hit && (hit_cnt_o != '1))   hit_cnt_o  <= hit_cnt_o + 1'b1;
      if (refill_fire && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: a line-address reference model predicts
// hit/miss per fetch, a monitor pops expectations on every if_ack_o.
module tb_icache_assoc;

  localparam int ADDR_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int LINE_W     = 128;
  localparam int SETS       = 64;
  localparam int WAYS       = 2;
  localparam int LINE_BYTES = LINE_W / 8;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               imem_sel_i = 1'b0;
  logic               if_req_i = 1'b0;
  logic               if_req_kill_i = 1'b0;
  logic               if_flush_i = 1'b0;
  logic [ADDR_W-1:0]  if_addr_i = '0;
  logic               if_ack_o;
  logic [INSTR_W-1:0] if_data_o;
  logic               if_busy_o;
  logic               mem_req_o;
  logic               mem_kill_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic               mem_ack_i = 1'b0;
  logic [LINE_W-1:0]  mem_data_i = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]        hit_cnt_o, miss_cnt_o;
`endif

  icache_assoc #(
    .ADDR_W (ADDR_W), .INSTR_W (INSTR_W), .LINE_W (LINE_W), .SETS (SETS), .WAYS (WAYS)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_sel_i    (imem_sel_i),
    .if_req_i      (if_req_i),
    .if_req_kill_i (if_req_kill_i),
    .if_flush_i    (if_flush_i),
    .if_addr_i     (if_addr_i),
    .if_ack_o      (if_ack_o),
    .if_data_o     (if_data_o),
    .if_busy_o     (if_busy_o),
    .mem_req_o     (mem_req_o),
    .mem_kill_o    (mem_kill_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    bit          hit;
  } exp_t;

  exp_t        exp_q[$];
  int          assert_cnt = 0;
  int          fail_cnt = 0;
  logic [31:0] exp_mem_addr = '0;
  logic [31:0] spur_base = '0;
  bit          mem_hold = 0;
  bit          spur_ack = 0;

  // Reference model: each set holds up to WAYS line addresses.
  int unsigned m_line [SETS][WAYS];
  bit          m_valid[SETS][WAYS];
  int          m_rr   [SETS];
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [LINE_W-1:0] line_data(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = mem_word(base + 32'(i * 4));
    return l;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned ln = a / LINE_BYTES;
    int          s  = int'(ln % SETS);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_line[s][w] == ln) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int unsigned ln = a / LINE_BYTES;
    int          s  = int'(ln % SETS);
    int          v  = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_line[s][v]  = ln;
  endfunction

  function automatic void model_clear(input bit full_reset);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      if (full_reset) m_rr[s] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // Memory responder: random 0..3 cycle latency, or forced acks for abort tests.
  initial begin
    int wait_cnt = -1;
    forever begin
      @(posedge clk_i);
      #2;
      mem_ack_i = 1'b0;
      if (spur_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = line_data(spur_base);
      end else if (mem_req_o && !mem_hold) begin
        if (wait_cnt < 0) begin
          checkOutput("mem_addr", mem_addr_o, exp_mem_addr);
          wait_cnt = int'($urandom_range(0, 3));
        end
        if (wait_cnt == 0) begin
          mem_ack_i  = 1'b1;
          mem_data_i = line_data(mem_addr_o);
        end
        wait_cnt--;
      end
    end
  end

  // Monitor: every ack must match the oldest expectation, hits must not refill.
  initial begin
    bit   saw_req = 0;
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni || mem_kill_o) saw_req = 0;
      else if (mem_req_o) saw_req = 1;
      if (if_ack_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("if_data", if_data_o, e.data);
          checkOutput("refill_seen", saw_req, !e.hit);
        end
        saw_req = 0;
      end
    end
  end

  task automatic countFlush();
    int busy = 0;
    for (int i = 0; i < SETS + 20; i++) begin
      @(negedge clk_i);
      if (if_busy_o) busy++;
      if (i == 5) begin
        if_req_i = 1'b1; imem_sel_i = 1'b1; if_addr_i = 32'h100;
      end else if (i == 6) begin
        if_req_i = 1'b0; imem_sel_i = 1'b0;
      end
    end
    checkOutput("flush_busy_cycles", busy, SETS);
    model_clear(1'b0);
  endtask

  task automatic doFlush(input bit with_req);
    @(posedge clk_i); #1;
    if_flush_i = 1'b1;
    if (with_req) begin
      if_req_i = 1'b1; imem_sel_i = 1'b1; if_addr_i = 32'h104;
    end
    @(posedge clk_i); #1;
    if_flush_i = 1'b0; if_req_i = 1'b0; imem_sel_i = 1'b0;
    countFlush();
  endtask

  // mode: 0 fetch, 1 kill in lookup, 2 kill in refill, 3 sel low, 4 flush during access
  task automatic applyStimulus(input logic [31:0] addr, input int mode_in);
    int mode = mode_in;
    bit hit  = model_hit(addr);
    int cycles = 0;
    if (mode == 2 && hit) mode = 0;
    @(posedge clk_i); #1;
    if_addr_i    = addr;
    if_req_i     = 1'b1;
    imem_sel_i   = (mode != 3);
    exp_mem_addr = addr & ~32'(LINE_BYTES - 1);
    mem_hold     = (mode == 2);
    if (mode == 0 || mode == 4) exp_q.push_back('{data: mem_word(addr & ~32'h3), hit: hit});
    @(posedge clk_i); #1;
    if_req_i   = 1'b0;
    imem_sel_i = 1'b0;
    case (mode)
      1: begin
        if_req_kill_i = 1'b1;
        @(negedge clk_i);
        checkOutput("kill_lookup_ack", if_ack_o, 0);
        @(posedge clk_i); #1;
        if_req_kill_i = 1'b0;
      end
      2: begin
        @(posedge clk_i); #1;
        checkOutput("refill_req_held", mem_req_o, 1);
        checkOutput("refill_addr", mem_addr_o, exp_mem_addr);
        if_req_kill_i = 1'b1;
        spur_base     = exp_mem_addr;
        spur_ack      = 1'b1;
        @(negedge clk_i);
        checkOutput("kill_pulse", {mem_kill_o, mem_req_o, if_ack_o}, 3'b100);
        @(posedge clk_i); #1;
        if_req_kill_i = 1'b0;
        spur_ack      = 1'b0;
        mem_hold      = 1'b0;
        @(negedge clk_i);
        checkOutput("kill_single_cycle", {mem_kill_o, if_ack_o}, 2'b00);
      end
      3: begin
        @(negedge clk_i);
        checkOutput("sel_low_ignored", {if_ack_o, mem_req_o}, 2'b00);
      end
      default: begin
        if (mode == 4) if_flush_i = 1'b1;
        do begin
          @(negedge clk_i);
          cycles++;
        end while (!if_ack_o && cycles < 40);
        checkOutput("ack_seen", if_ack_o, 1);
        if (hit) checkOutput("hit_latency", cycles, 1);
        if (hit) m_hits++;
        else begin
          m_misses++;
          model_fill(addr);
        end
        if (mode == 4) begin
          @(posedge clk_i); #1;
          if_flush_i = 1'b0;
          countFlush();
        end
      end
    endcase
  endtask

  task automatic resetMidRefill(input logic [31:0] addr);
    @(posedge clk_i); #1;
    if_addr_i = addr; if_req_i = 1'b1; imem_sel_i = 1'b1; mem_hold = 1'b1;
    @(posedge clk_i); #1;
    if_req_i = 1'b0; imem_sel_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("pre_reset_refill", mem_req_o, 1);
    spur_base = addr & ~32'(LINE_BYTES - 1);
    spur_ack  = 1'b1;
    rst_ni    = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_flags", {if_ack_o, mem_req_o, mem_kill_o, if_busy_o}, 4'b0000);
    checkOutput("reset_data_addr", {if_data_o, mem_addr_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("late_ack_ignored", if_ack_o, 0);
    @(posedge clk_i); #1;
    spur_ack = 1'b0;
    mem_hold = 1'b0;
    model_clear(1'b1);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    model_clear(1'b1);
    @(negedge clk_i);
    checkOutput("reset_flags", {if_ack_o, mem_req_o, mem_kill_o, if_busy_o}, 4'b0000);
    checkOutput("reset_data_addr", {if_data_o, mem_addr_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    applyStimulus(32'h0000_0100, 0);
    applyStimulus(32'h0000_0104, 0);
    applyStimulus(32'h0000_0000, 0);
    applyStimulus(32'h0000_0400, 0);
    applyStimulus(32'h0000_0800, 0);
    applyStimulus(32'h0000_0400, 0);
    applyStimulus(32'h0000_0000, 0);
    applyStimulus(32'h0000_3040, 2);
    applyStimulus(32'h0000_3040, 0);
    applyStimulus(32'h0000_0108, 1);
    applyStimulus(32'h0000_0108, 3);
    doFlush(1'b0);
    applyStimulus(32'h0000_0100, 0);
    applyStimulus(32'h0000_0800, 0);
    resetMidRefill(32'h0000_0500);
    applyStimulus(32'h0000_0500, 0);
    applyStimulus(32'h0000_0104, 4);
    applyStimulus(32'h0000_0104, 0);

    for (int n = 0; n < 250; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      r = int'($urandom_range(0, 39));
      if      (r == 0)  applyStimulus(a, 1);
      else if (r <= 3)  applyStimulus(a, 2);
      else if (r == 4)  applyStimulus(a, 3);
      else if (r == 5)  doFlush($urandom_range(0, 1) == 1);
      else if (r == 6)  applyStimulus(a, 4);
      else              applyStimulus(a, 0);
    end
    doFlush(1'b1);

    repeat (3) @(negedge clk_i);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
`ifdef ICACHE_PERF_CNT_EN
    checkOutput("hit_cnt", hit_cnt_o, m_hits);
    checkOutput("miss_cnt", miss_cnt_o, m_misses);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
